// File: rtl/seg_scan_capture.sv
// Receive side of a 3-digit multiplexed 7-segment bus: recovers a 12-bit BCD frame.
// Optional macro SEG_SCAN_DP_CAPTURE_EN adds dp_out and captures the decimal point per digit.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  en_in,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic        dec_err,
  output logic        stale
`ifdef SEG_SCAN_DP_CAPTURE_EN
  ,
  output logic [2:0]  dp_out
`endif
);

`ifdef SEG_SCAN_DP_CAPTURE_EN
  localparam int unsigned PatW = 8;
`else
  localparam int unsigned PatW = 7;
`endif
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  // Two-flop synchronisers, reset to the idle (unlit / deselected) pin level.
  logic [PatW-1:0] seg_s1_q, seg_s2_q;
  logic [2:0]      en_s1_q, en_s2_q;

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [PatW-1:0] seg_pins;
  assign seg_pins = seg_in;
`else
  logic [PatW-1:0] seg_pins;
  logic            unused_dp;
  assign seg_pins  = seg_in[6:0];
  assign unused_dp = seg_in[7];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= {PatW{SEG_ACTIVE_LOW}};
      seg_s2_q <= {PatW{SEG_ACTIVE_LOW}};
      en_s1_q  <= {3{EN_ACTIVE_LOW}};
      en_s2_q  <= {3{EN_ACTIVE_LOW}};
    end else begin
      seg_s1_q <= seg_pins;
      seg_s2_q <= seg_s1_q;
      en_s1_q  <= en_in;
      en_s2_q  <= en_s1_q;
    end
  end

  logic [PatW-1:0] p;
  logic [2:0]      e;
  assign p = seg_s2_q ^ {PatW{SEG_ACTIVE_LOW}};
  assign e = en_s2_q ^ {3{EN_ACTIVE_LOW}};

  logic       e_onehot;
  logic [1:0] e_idx;
  assign e_onehot = (e == 3'b001) || (e == 3'b010) || (e == 3'b100);
  assign e_idx    = e[2] ? 2'd2 : (e[1] ? 2'd1 : 2'd0);

  // Returns {illegal, digit}; blanked digit reads as 0.
  function automatic logic [4:0] decode(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3f, 7'h00: r = 5'h00;
      7'h06:        r = 5'h01;
      7'h5b:        r = 5'h02;
      7'h4f:        r = 5'h03;
      7'h66:        r = 5'h04;
      7'h6d:        r = 5'h05;
      7'h7d:        r = 5'h06;
      7'h07, 7'h27: r = 5'h07;
      7'h7f:        r = 5'h08;
      7'h6f:        r = 5'h09;
      default:      r = 5'h1f;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      lat_e_q, lat_e_d;
  logic [PatW-1:0] lat_p_q, lat_p_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            eval;

  always_comb begin
    state_d = state_q;
    lat_e_d = lat_e_q;
    lat_p_d = lat_p_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    eval    = 1'b0;
    case (state_q)
      StIdle: eval = 1'b1;
      StSettle: begin
        if ((e == lat_e_q) && (p == lat_p_q)) begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            accept  = 1'b1;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          eval = 1'b1;
        end
      end
      StHold: eval = (e != lat_e_q);
      default: state_d = StIdle;
    endcase
    // Fresh evaluation: first sample of a new candidate digit.
    if (eval) begin
      if (e_onehot) begin
        lat_e_d = e;
        lat_p_d = p;
        cnt_d   = CntW'(1);
        if (SETTLE_CYCLES <= 1) begin
          accept  = 1'b1;
          state_d = StHold;
        end else begin
          state_d = StSettle;
        end
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lat_e_q <= '0;
      lat_p_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_e_q <= lat_e_d;
      lat_p_q <= lat_p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accepted pattern always equals the current sample (p, e).
  logic [4:0] dec;
  assign dec = decode(p[6:0]);

  logic [2:0][3:0] shadow_q, shadow_d;
  logic [2:0]      seen_q, seen_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            dec_err_q, dec_err_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            frame_out;
  logic            store_err;

  assign frame_out = (seen_q == 3'b111);
  assign store_err = accept && dec[4];

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = frame_out ? 3'b000 : seen_q;
    if (accept) begin
      shadow_d[e_idx] = dec[3:0];
      seen_d[e_idx]   = 1'b1;
    end
    bcd_d       = frame_out ? shadow_q : bcd_q;
    valid_d     = frame_out;
    // Errors of the frame being delivered survive; a new error sets on top.
    frame_err_d = (frame_out ? 1'b0 : frame_err_q) | store_err;
    dec_err_d   = (frame_out ? frame_err_q : dec_err_q) | store_err;
    if (frame_out) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      seen_q      <= '0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      dec_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      shadow_q    <= shadow_d;
      seen_q      <= seen_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      dec_err_q   <= dec_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

`ifdef SEG_SCAN_DP_CAPTURE_EN
  logic [2:0] dp_shadow_q, dp_shadow_d;
  logic [2:0] dp_q, dp_d;

  always_comb begin
    dp_shadow_d = dp_shadow_q;
    if (accept) dp_shadow_d[e_idx] = p[7];
    dp_d = frame_out ? dp_shadow_q : dp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_shadow_q <= '0;
      dp_q        <= '0;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
    end
  end

  assign dp_out = dp_q;
`endif

  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign dec_err   = dec_err_q;
  assign stale     = (to_cnt_q == ToW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: frame table plus glitch, multi-enable, latency,
// timeout and mid-frame reset sequences.
module tb_seg_scan_capture;
  localparam int unsigned Settle  = 4;
  localparam int unsigned Timeout = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = 8'hff;
  logic [2:0]  en_in = 3'b111;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic        dec_err;
  logic        stale;

  seg_scan_capture #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout),
    .SEG_ACTIVE_LOW(1'b1),
    .EN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .en_in    (en_in),
    .bcd_out  (bcd_out),
    .bcd_valid(bcd_valid),
    .dec_err  (dec_err),
    .stale    (stale)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records every valid pulse and the outputs seen alongside it.
  int          vcount = 0;
  logic [11:0] last_bcd = '0;
  logic        last_err = 1'b0;
  logic        last_stale = 1'b0;
  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      vcount++;
      last_bcd   = bcd_out;
      last_err   = dec_err;
      last_stale = stale;
    end
  end

  // Drive active-high enable/pattern onto active-low pins, hold for n rising edges.
  task automatic put(input logic [2:0] en, input logic [7:0] pat, input int n);
    en_in  = ~en;
    seg_in = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] o, input logic [7:0] t, input logic [7:0] h);
    put(3'b001, o, 8);
    put(3'b010, t, 8);
    put(3'b100, h, 8);
    put(3'b000, 8'h00, 10);
  endtask

  typedef struct {
    logic [7:0]  o;
    logic [7:0]  t;
    logic [7:0]  h;
    logic [11:0] bcd;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int lat;

    vecs[0] = '{o: 8'h4f, t: 8'h5b, h: 8'h06, bcd: 12'h123, err: 1'b0};
    vecs[1] = '{o: 8'h7d, t: 8'h6d, h: 8'h66, bcd: 12'h456, err: 1'b0};
    vecs[2] = '{o: 8'h6f, t: 8'h7f, h: 8'h07, bcd: 12'h789, err: 1'b0};
    vecs[3] = '{o: 8'h27, t: 8'h00, h: 8'h3f, bcd: 12'h007, err: 1'b0};
    vecs[4] = '{o: 8'h06, t: 8'h49, h: 8'h06, bcd: 12'h1f1, err: 1'b1};
    vecs[5] = '{o: 8'h5b, t: 8'h4f, h: 8'h66, bcd: 12'h432, err: 1'b0};

    repeat (3) @(negedge clk);
    check("reset bcd_out", 32'(bcd_out), 32'h0);
    check("reset bcd_valid", 32'(bcd_valid), 32'h0);
    check("reset dec_err", 32'(dec_err), 32'h0);
    check("reset stale", 32'(stale), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v0 = vcount;
      frame(vecs[i].o, vecs[i].t, vecs[i].h);
      check($sformatf("frame%0d valid_count", i), 32'(vcount - v0), 32'd1);
      check($sformatf("frame%0d bcd_out", i), 32'(last_bcd), 32'(vecs[i].bcd));
      check($sformatf("frame%0d dec_err", i), 32'(last_err), 32'(vecs[i].err));
      check($sformatf("frame%0d stale", i), 32'(last_stale), 32'h0);
    end

    // Digit held one sample short of settling must not be stored.
    v0 = vcount;
    put(3'b001, 8'h06, Settle - 1);
    put(3'b001, 8'h7d, Settle - 1);
    put(3'b000, 8'h00, 6);
    put(3'b010, 8'h5b, 8);
    put(3'b100, 8'h66, 8);
    put(3'b000, 8'h00, 10);
    check("glitch no_valid", 32'(vcount - v0), 32'd0);
    put(3'b001, 8'h4f, Settle);
    put(3'b000, 8'h00, 10);
    check("exact_settle valid_count", 32'(vcount - v0), 32'd1);
    check("exact_settle bcd_out", 32'(last_bcd), 32'h423);

    // Two enables at once never capture.
    v0 = vcount;
    put(3'b011, 8'h06, 20);
    put(3'b000, 8'h00, 4);
    check("multi_en no_valid", 32'(vcount - v0), 32'd0);

    put(3'b001, 8'h6f, 8);
    put(3'b010, 8'h3f, 8);
    en_in  = ~3'b100;
    seg_in = ~8'h3f;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bcd_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("last_digit latency", 32'(lat), 32'(2 + Settle + 1));
    check("009 bcd_out", 32'(bcd_out), 32'h009);

    // Valid edge is behind us; count cycles to saturation.
    repeat (Timeout - 1) @(posedge clk);
    #1;
    check("stale before timeout", 32'(stale), 32'h0);
    @(posedge clk);
    #1;
    check("stale at timeout", 32'(stale), 32'h1);
    check("009 valid_count", 32'(vcount - v0), 32'd1);
    @(negedge clk);

    v0 = vcount;
    frame(8'h06, 8'h5b, 8'h4f);
    check("recover valid_count", 32'(vcount - v0), 32'd1);
    check("recover bcd_out", 32'(last_bcd), 32'h321);
    check("recover stale_at_valid", 32'(last_stale), 32'h0);
    check("recover stale_now", 32'(stale), 32'h0);

    // Reset after two digits: partial frame must be discarded.
    v0 = vcount;
    put(3'b001, 8'h66, 8);
    put(3'b010, 8'h6d, 8);
    rst_n = 1'b0;
    #1;
    check("midreset bcd_out", 32'(bcd_out), 32'h0);
    check("midreset bcd_valid", 32'(bcd_valid), 32'h0);
    check("midreset dec_err", 32'(dec_err), 32'h0);
    check("midreset stale", 32'(stale), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    put(3'b100, 8'h7d, 8);
    put(3'b000, 8'h00, 20);
    check("midreset no_valid", 32'(vcount - v0), 32'd0);
    check("midreset bcd_hold", 32'(bcd_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
